mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Two-master arbiter in front of the physical memory controller's single request port.
- Master 0 is the CPU memory port. Master 1 is a block-copy/DMA engine, such as a flash-to-RAM loader or VGA framebuffer filler.
- Serialises accesses, one transaction in flight at a time, with round-robin fairness.
- Includes a busy watchdog so a hung access cannot lock the bus.

Parameters:
ADDR_WIDTH, 32, address width of both masters and memory port
DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 1023, max cycles spent in WAIT_* before abort
CNT_WIDTH, 10, width of watchdog counter (must hold TIMEOUT_CYCLES)

Ports:
clk50M  in  1  system clock; sole clock
rst  in  1  reset, asynchronous, active-low
m0_req, m1_req  in  1 each  request; held high until matching done pulse
m0_is_write, m1_is_write  in  1 each  1 = write
m0_addr, m1_addr  in  ADDR_WIDTH each  request address
m0_wdata, m1_wdata  in  DATA_WIDTH each  write data
m0_rdata, m1_rdata  out  DATA_WIDTH each  read data, valid in done cycle and held after
m0_done, m1_done  out  1 each  one-cycle completion pulse
grant  out  2  one-hot owner of the memory port; 0 when idle
mem_req  out  1  one-cycle start strobe to memory controller
mem_is_write  out  1  latched direction
mem_addr  out  ADDR_WIDTH  latched address
mem_wdata  out  DATA_WIDTH  latched write data
mem_rdata  in  DATA_WIDTH  read data from controller
mem_busy  in  1  controller busy
timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, last=1. All outputs are 0: grant, mem_req, mem_is_write, mem_addr, mem_wdata, m*_rdata, m*_done, timeout_err. Watchdog counter is 0.
- Downstream contract: mem_busy rises within 2 cycles after the mem_req cycle and stays high at least 1 cycle. The first cycle with mem_busy low after having been high is completion; mem_rdata is valid in that cycle.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: if exactly one req is high, select it. If both are high, select the master != last. Latch is_write/addr/wdata into mem_*, set grant one-hot, go ISSUE. If no req, stay and keep grant=0.
- ISSUE: mem_req=1 for exactly this cycle. Clear counter, go WAIT_BUSY.
- WAIT_BUSY: when mem_busy=1, go WAIT_DONE. Counter increments every cycle in WAIT_BUSY and WAIT_DONE.
- WAIT_DONE: when mem_busy=0, capture mem_rdata into the granted m*_rdata (reads only; writes leave rdata unchanged), go DONE.
- Timeout: counter reaching TIMEOUT_CYCLES in either WAIT state sets timeout_err and goes DONE. No rdata capture on timeout.
- DONE: assert the granted m*_done for 1 cycle, set last=granted index, grant=0, go IDLE.
- Minimum latency: req sampled in IDLE at cycle 0 → ISSUE at 1 → WAIT_BUSY at 2 → WAIT_DONE at 3 (busy seen at 2) → busy low seen at 3 → DONE/done pulse at cycle 4.
- Masters must deassert req in the cycle after done. A req still high in the IDLE cycle after DONE is treated as a new transaction.
- mem_addr, mem_wdata and mem_is_write hold their values from IDLE-latch until the next latch; they are never cleared mid-transaction.
- Master inputs are ignored outside IDLE. A master changing addr while waiting is not seen.
- A req arriving while the other master owns the port waits. Round-robin then guarantees it is served next: at most one foreign transaction of delay.
- Reset asserted mid-transaction aborts immediately with no done pulse. The memory controller shares the reset.

Decomposition:
- Shared package holds the state encoding constants (3-bit: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3, DONE=4) and master index constants (CPU=0, DMA=1). Place them in a header alongside the existing VGA definitions header.
- One natural sub-module: rr_pick2. Combinational, 2-request round-robin picker taking req[1:0] and last, producing a one-hot winner. Reusable for interrupt sources.

Test Plan:
- Single read: m0_req with addr=0x00000010; model holds busy 3 cycles, returns 0xDEADBEEF → mem_req pulse once with mem_addr=0x10; m0_done 1 cycle; m0_rdata=0xDEADBEEF; grant 01→00.
- Simultaneous requests after reset: m0 write 0x100/0x11111111 and m1 read 0x200 → m0 served first (last=1), then m1. mem_addr sequence is 0x100 then 0x200; no done overlap.
- Fairness: m0 and m1 both requesting continuously for 6 transactions → grant alternates 01,10,01,10,01,10.
- Timeout: TIMEOUT_CYCLES=8, model never raises busy → done pulse for the granted master 8 cycles after ISSUE; timeout_err=1 and sticky; rdata unchanged; next request still served.
- Minimum latency: busy high exactly 1 cycle starting the cycle after mem_req → done at cycle 4 relative to req sample.
- Reset mid-op: assert rst low while in WAIT_DONE → all outputs 0 asynchronously; no done pulse; after release, m1_req alone is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter: FSM encoding,
// master indices and a one-hot-to-index helper.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

  function automatic logic grant_idx(input logic [1:0] grant_oh);
    return grant_oh[1];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-request round-robin picker; on a tie the requester that
// was not served last wins. Output is one-hot, zero when nothing requests.
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = (last == MASTER_DMA) ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU (master 0) and DMA (master 1) accesses onto the single memory
// controller request port, one transaction at a time, with a busy watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_WIDTH      = 10
)(
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_is_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_done,
  input  logic                  m1_req,
  input  logic                  m1_is_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_done,
  output logic [1:0]            grant,
  output logic                  mem_req,
  output logic                  mem_is_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_busy,
  output logic                  timeout_err
);

  // Counter value seen in the last permitted WAIT cycle; leaving on it means
  // exactly TIMEOUT_CYCLES cycles were spent waiting.
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_e           state;
  logic                 last;
  logic [CNT_WIDTH-1:0] wd_cnt;
  logic [1:0]           winner;
  logic                 timed_out;

  mem_port_arbiter_rr_pick2 u_pick (
    .req    ({m1_req, m0_req}),
    .last   (last),
    .winner (winner)
  );

  assign timed_out = (wd_cnt >= TO_LAST);

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      last         <= MASTER_DMA;
      wd_cnt       <= '0;
      grant        <= 2'b00;
      mem_req      <= 1'b0;
      mem_is_write <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (winner != 2'b00) begin
            grant        <= winner;
            mem_is_write <= winner[1] ? m1_is_write : m0_is_write;
            mem_addr     <= winner[1] ? m1_addr     : m0_addr;
            mem_wdata    <= winner[1] ? m1_wdata    : m0_wdata;
            mem_req      <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (mem_busy) begin
            state <= ST_WAIT_DONE;
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            m0_done     <= grant[0];
            m1_done     <= grant[1];
            state       <= ST_DONE;
          end
        end
        ST_WAIT_DONE: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (!mem_busy) begin
            if (!mem_is_write) begin
              if (grant_idx(grant) == MASTER_CPU) m0_rdata <= mem_rdata;
              else                                m1_rdata <= mem_rdata;
            end
            m0_done <= grant[0];
            m1_done <= grant[1];
            state   <= ST_DONE;
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            m0_done     <= grant[0];
            m1_done     <= grant[1];
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          last  <= grant_idx(grant);
          grant <= 2'b00;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
